// File: rtl/uart_tx_ram_sched.sv
// uart_tx_ram_sched
//   Burst transmit sequencer between a byte RAM and a UART transmitter.
//   A start command latches a base address and a byte count. Bytes are then
//   fetched one at a time: READ strobes the RAM, WAIT_DATA captures the byte,
//   and PULSE issues a one-cycle tx_int. The frame is tracked through tx_end
//   rising (WAIT_BUSY) and falling (WAIT_IDLE). An optional idle gap follows
//   each frame before the next fetch.
//   A watchdog ends the burst with err if a frame stalls. Abort ends the burst
//   at once when no frame is in flight; otherwise it ends after the current
//   frame.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle burst request, accepted only in IDLE
//   base_addr, length burst start address and byte count (0..2^ADDR_W)
//   abort             request to end the burst early
//   ram_rd_en         RAM read strobe (one cycle per byte)
//   ram_addr          RAM read address
//   ram_rd_data       RAM data, valid the cycle after ram_rd_en
//   tx_data           byte presented to the transmitter
//   tx_int            one-cycle transmit trigger
//   tx_end            transmitter busy flag
//   busy              high whenever the sequencer is not IDLE
//   done              one-cycle end-of-burst pulse
//   err               watchdog timeout flag, sticky until the next start
//   bytes_sent        frames completed in the current/last burst
//   state_dbg         current FSM state encoding
//
// Handshake: there is no valid/ready pair here. tx_int is a single-cycle
// trigger, and the transmitter reports its own progress on tx_end. The RAM is
// a fixed one-cycle-latency read port with no back-pressure.

module uart_tx_ram_sched #(
  parameter int ADDR_W     = 8,
  parameter int GAP_CYCLES = 0,
  parameter int TO_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_int,
  input  logic              tx_end,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   bytes_sent,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_PULSE     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_GAP       = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [19:0]       TO_LIM   = 20'(TO_CYCLES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     sent_q, sent_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [19:0]         wd_q, wd_d;
  logic                abort_pend_q, abort_pend_d;
  logic                err_q, err_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                rd_en_q, rd_en_d;
  logic                tx_int_q, tx_int_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ADDR_W:0]     sent_inc;
  logic [19:0]         wd_inc;
  logic                timeout;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    sent_d       = sent_q;
    gap_d        = gap_q;
    wd_d         = wd_q;
    abort_pend_d = abort_pend_q;
    err_d        = err_q;
    tx_data_d    = tx_data_q;

    sent_inc = sent_q + 1'b1;
    wd_inc   = wd_q + 20'd1;
    // The watchdog measures cycles since the trigger: PULSE loads 1, so the
    // limit is hit TO_CYCLES cycles after the tx_int cycle.
    timeout  = (wd_inc == TO_LIM);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sent_d       = '0;
          err_d        = 1'b0;
          abort_pend_d = 1'b0;
          if (length != '0) begin
            addr_d  = base_addr;
            len_d   = length;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        state_d = abort ? S_DONE : S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (abort) begin
          state_d = S_DONE;
        end else begin
          tx_data_d = ram_rd_data;
          state_d   = S_PULSE;
        end
      end
      S_PULSE: begin
        wd_d    = 20'd1;
        if (abort) abort_pend_d = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        wd_d = wd_inc;
        if (abort) abort_pend_d = 1'b1;
        // Timeout takes priority over abort and over frame progress.
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (tx_end) begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        wd_d = wd_inc;
        if (abort) abort_pend_d = 1'b1;
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!tx_end) begin
          sent_d = sent_inc;
          addr_d = addr_q + 1'b1;
          if ((sent_inc == len_q) || abort_pend_q || abort) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES != 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_READ;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so that they come out of flops
    // and line up with the state they belong to.
    rd_en_d  = (state_d == S_READ);
    tx_int_d = (state_d == S_PULSE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      sent_q       <= '0;
      gap_q        <= '0;
      wd_q         <= '0;
      abort_pend_q <= 1'b0;
      err_q        <= 1'b0;
      tx_data_q    <= '0;
      rd_en_q      <= 1'b0;
      tx_int_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      sent_q       <= sent_d;
      gap_q        <= gap_d;
      wd_q         <= wd_d;
      abort_pend_q <= abort_pend_d;
      err_q        <= err_d;
      tx_data_q    <= tx_data_d;
      rd_en_q      <= rd_en_d;
      tx_int_q     <= tx_int_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ram_rd_en  = rd_en_q;
  assign ram_addr   = addr_q;
  assign tx_data    = tx_data_q;
  assign tx_int     = tx_int_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign bytes_sent = sent_q;
  assign state_dbg  = state_q;

endmodule
